// File: rtl/usb2_ep_pkg.sv
// Shared encodings and helpers for the USB 2.0 endpoint packet ring.
package usb2_ep_pkg;

    typedef enum logic [1:0] {
        EP_MODE_CTRL  = 2'd0,
        EP_MODE_ISOCH = 2'd1,
        EP_MODE_BULK  = 2'd2,
        EP_MODE_INTR  = 2'd3
    } ep_mode_e;

    typedef enum logic [1:0] {
        DATA_TOGGLE_0 = 2'd0,
        DATA_TOGGLE_1 = 2'd1,
        DATA_TOGGLE_2 = 2'd2,
        DATA_TOGGLE_M = 2'd3
    } data_toggle_e;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/usb2_ep_ram.sv
// Single-clock simple dual-port byte RAM with registered read.
// A write and read to the same address in one cycle returns the old data.
module usb2_ep_ram #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_q
);

    logic [7:0] mem [2**AW];

    // Storage array: no reset, contents survive a ring reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read port; old data wins on a same-address write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_q <= '0;
        else        rd_q <= mem[rd_addr];
    end

endmodule

// File: rtl/usb2_ep_ring.sv
// N-deep packet ring for one USB 2.0 endpoint with PID data-toggle tracking.
// Optional feature macro: USB2_EP_HALT_EN adds endpoint halt (halt_set/halt_clr/halted).
module usb2_ep_ring
    import usb2_ep_pkg::*;
#(
    parameter int NBUF   = 4,
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 10
) (
    input  logic                   phy_clk,
    input  logic                   reset_n,
    input  logic [ADDR_W-1:0]      buf_in_addr,
    input  logic [7:0]             buf_in_data,
    input  logic                   buf_in_wren,
    output logic                   buf_in_ready,
    input  logic                   buf_in_commit,
    input  logic [LEN_W-1:0]       buf_in_commit_len,
    output logic                   buf_in_commit_ack,
    input  logic [ADDR_W-1:0]      buf_out_addr,
    output logic [7:0]             buf_out_q,
    output logic [LEN_W-1:0]       buf_out_len,
    output logic                   buf_out_hasdata,
    input  logic                   buf_out_arm,
    output logic                   buf_out_arm_ack,
    output logic [clog2(NBUF):0]   fill_count,
    input  logic [1:0]             mode,
    input  logic [1:0]             mult,
    input  logic                   sof,
    input  logic                   toggle_clr,
    input  logic                   data_toggle_act,
    output logic [1:0]             data_toggle
`ifdef USB2_EP_HALT_EN
    ,
    input  logic                   halt_set,
    input  logic                   halt_clr,
    output logic                   halted
`endif
);

    localparam int PW = clog2(NBUF);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]    FULL     = CW'(NBUF);
    localparam logic [LEN_W-1:0] SLOT_LEN = LEN_W'(2**ADDR_W);

    logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic [LEN_W-1:0] len_mem [NBUF];
    logic [LEN_W-1:0] clip_len, out_len_nxt;
    logic             commit_ok, arm_ok;
    logic             halted_nxt, halt_clr_act;
    data_toggle_e     tog_q, tog_nxt, isoch_start;

`ifdef USB2_EP_HALT_EN
    // halt_set wins over halt_clr.
    always_comb begin
        halted_nxt   = halted;
        halt_clr_act = 1'b0;
        if (halt_set) begin
            halted_nxt = 1'b1;
        end else if (halt_clr) begin
            halted_nxt   = 1'b0;
            halt_clr_act = 1'b1;
        end
    end

    // Halt flag register.
    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) halted <= 1'b0;
        else          halted <= halted_nxt;
    end
`else
    logic halted;
    assign halted       = 1'b0;
    assign halted_nxt   = 1'b0;
    assign halt_clr_act = 1'b0;
`endif

    usb2_ep_ram #(.AW(PW + ADDR_W)) u_ram (
        .clk     (phy_clk),
        .rst_n   (reset_n),
        .wr_en   (buf_in_wren & buf_in_ready),
        .wr_addr ({wr_ptr, buf_in_addr}),
        .wr_data (buf_in_data),
        .rd_addr ({rd_ptr, buf_out_addr}),
        .rd_q    (buf_out_q)
    );

    // Accept decisions use the pre-cycle count; next pointer/count/length state.
    always_comb begin
        commit_ok  = buf_in_commit && (count != FULL);
        arm_ok     = buf_out_arm && (count != '0) && !halted;
        clip_len   = (buf_in_commit_len > SLOT_LEN) ? SLOT_LEN : buf_in_commit_len;
        wr_ptr_nxt = commit_ok ? wr_ptr + PW'(1) : wr_ptr;
        rd_ptr_nxt = arm_ok    ? rd_ptr + PW'(1) : rd_ptr;
        count_nxt  = count;
        if (commit_ok && !arm_ok)      count_nxt = count + CW'(1);
        else if (arm_ok && !commit_ok) count_nxt = count - CW'(1);
        // Forward the length being written if it lands in the next oldest slot.
        if (count_nxt == '0)                       out_len_nxt = '0;
        else if (commit_ok && wr_ptr == rd_ptr_nxt) out_len_nxt = clip_len;
        else                                       out_len_nxt = len_mem[rd_ptr_nxt];
    end

    // Ring state, length array and registered status/ack outputs.
    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            for (int i = 0; i < NBUF; i++) len_mem[i] <= '0;
            buf_out_len       <= '0;
            buf_in_ready      <= 1'b1;
            buf_out_hasdata   <= 1'b0;
            buf_in_commit_ack <= 1'b0;
            buf_out_arm_ack   <= 1'b0;
        end else begin
            if (commit_ok) len_mem[wr_ptr] <= clip_len;
            wr_ptr            <= wr_ptr_nxt;
            rd_ptr            <= rd_ptr_nxt;
            count             <= count_nxt;
            buf_out_len       <= out_len_nxt;
            buf_in_ready      <= (count_nxt != FULL);
            buf_out_hasdata   <= (count_nxt != '0) && !halted_nxt;
            buf_in_commit_ack <= commit_ok;
            buf_out_arm_ack   <= arm_ok;
        end
    end

    assign fill_count = count;

    // Isoch high-bandwidth start PID: DATA(mult-1), mult=0 behaves as 1.
    always_comb begin
        case (mult)
            2'd3:    isoch_start = DATA_TOGGLE_2;
            2'd2:    isoch_start = DATA_TOGGLE_1;
            default: isoch_start = DATA_TOGGLE_0;
        endcase
    end

    // Toggle state register.
    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) tog_q <= DATA_TOGGLE_0;
        else          tog_q <= tog_nxt;
    end

    // Toggle next state: clear > sof > transaction advance.
    always_comb begin
        tog_nxt = tog_q;
        if (toggle_clr || halt_clr_act) begin
            tog_nxt = DATA_TOGGLE_0;
        end else if (sof && mode == EP_MODE_ISOCH) begin
            tog_nxt = isoch_start;
        end else if (data_toggle_act) begin
            if (mode == EP_MODE_ISOCH)
                tog_nxt = (tog_q == DATA_TOGGLE_0) ? DATA_TOGGLE_0 : data_toggle_e'(tog_q - 2'd1);
            else
                tog_nxt = (tog_q == DATA_TOGGLE_1) ? DATA_TOGGLE_0 : DATA_TOGGLE_1;
        end
    end

    // Toggle output decode.
    always_comb begin
        data_toggle = tog_q;
    end

endmodule

// File: tb/tb_usb2_ep_ring.sv
// Directed bench for usb2_ep_ring with a packet scoreboard.
module tb_usb2_ep_ring;

    localparam int NBUF = 4, ADDR_W = 9, LEN_W = 10, CW = 3;

    logic              phy_clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W-1:0] buf_in_addr = '0;
    logic [7:0]        buf_in_data = '0;
    logic              buf_in_wren = 1'b0;
    logic              buf_in_ready;
    logic              buf_in_commit = 1'b0;
    logic [LEN_W-1:0]  buf_in_commit_len = '0;
    logic              buf_in_commit_ack;
    logic [ADDR_W-1:0] buf_out_addr = '0;
    logic [7:0]        buf_out_q;
    logic [LEN_W-1:0]  buf_out_len;
    logic              buf_out_hasdata;
    logic              buf_out_arm = 1'b0;
    logic              buf_out_arm_ack;
    logic [CW-1:0]     fill_count;
    logic [1:0]        mode = 2'd2;
    logic [1:0]        mult = 2'd1;
    logic              sof = 1'b0;
    logic              toggle_clr = 1'b0;
    logic              data_toggle_act = 1'b0;
    logic [1:0]        data_toggle;
`ifdef USB2_EP_HALT_EN
    logic              halt_set = 1'b0;
    logic              halt_clr = 1'b0;
    logic              halted;
`endif

    usb2_ep_ring #(.NBUF(NBUF), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .phy_clk(phy_clk), .reset_n(reset_n),
        .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
        .buf_in_ready(buf_in_ready), .buf_in_commit(buf_in_commit),
        .buf_in_commit_len(buf_in_commit_len), .buf_in_commit_ack(buf_in_commit_ack),
        .buf_out_addr(buf_out_addr), .buf_out_q(buf_out_q), .buf_out_len(buf_out_len),
        .buf_out_hasdata(buf_out_hasdata), .buf_out_arm(buf_out_arm),
        .buf_out_arm_ack(buf_out_arm_ack), .fill_count(fill_count),
        .mode(mode), .mult(mult), .sof(sof), .toggle_clr(toggle_clr),
        .data_toggle_act(data_toggle_act), .data_toggle(data_toggle)
`ifdef USB2_EP_HALT_EN
        , .halt_set(halt_set), .halt_clr(halt_clr), .halted(halted)
`endif
    );

    always #5 phy_clk = ~phy_clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        b;
        logic [LEN_W-1:0]  len;
    } pkt_t;

    pkt_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic tick();
        @(posedge phy_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        buf_in_addr = a; buf_in_data = d; buf_in_wren = 1'b1;
        tick();
        buf_in_wren = 1'b0;
    endtask

    task automatic do_commit(input logic [LEN_W-1:0] len, input logic exp_ack);
        buf_in_commit = 1'b1; buf_in_commit_len = len;
        tick();
        buf_in_commit = 1'b0;
        check("commit_ack", {31'd0, buf_in_commit_ack}, {31'd0, exp_ack});
    endtask

    function automatic logic [LEN_W-1:0] clip(input logic [LEN_W-1:0] l);
        return (l > LEN_W'(512)) ? LEN_W'(512) : l;
    endfunction

    // Producer: write one marker byte, commit, record expectation.
    task automatic push_pkt(input logic [ADDR_W-1:0] a, input logic [7:0] d, input logic [LEN_W-1:0] len);
        pkt_t p;
        write_byte(a, d);
        do_commit(len, 1'b1);
        p.addr = a; p.b = d; p.len = clip(len);
        sb.push_back(p);
    endtask

    // Read the oldest slot and compare against the scoreboard head.
    task automatic read_head();
        pkt_t p;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty");
        end else begin
            p = sb.pop_front();
            buf_out_addr = p.addr;
            tick();
            check("out_len", 32'(buf_out_len), 32'(p.len));
            check("out_q", 32'(buf_out_q), 32'(p.b));
        end
    endtask

    task automatic do_arm(input logic exp_ack);
        buf_out_arm = 1'b1;
        tick();
        buf_out_arm = 1'b0;
        check("arm_ack", {31'd0, buf_out_arm_ack}, {31'd0, exp_ack});
    endtask

    task automatic consume();
        read_head();
        do_arm(1'b1);
    endtask

    task automatic tog_step(input logic s, input logic c, input logic a, input logic [1:0] exp);
        sof = s; toggle_clr = c; data_toggle_act = a;
        tick();
        sof = 1'b0; toggle_clr = 1'b0; data_toggle_act = 1'b0;
        check("toggle", 32'(data_toggle), 32'(exp));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_ready", 32'(buf_in_ready), 32'd1);
        check("rst_hasdata", 32'(buf_out_hasdata), 32'd0);
        check("rst_len", 32'(buf_out_len), 32'd0);
        check("rst_q", 32'(buf_out_q), 32'd0);
        check("rst_fill", 32'(fill_count), 32'd0);
        check("rst_toggle", 32'(data_toggle), 32'd0);
        check("rst_cack", 32'(buf_in_commit_ack), 32'd0);
        check("rst_aack", 32'(buf_out_arm_ack), 32'd0);
        reset_n = 1'b1;
        tick();

        // Fill all four slots, then a dropped fifth commit
        push_pkt(9'd0, 8'hA0, 10'd64);
        push_pkt(9'd0, 8'hA1, 10'd128);
        push_pkt(9'd0, 8'hA2, 10'd3);
        push_pkt(9'd0, 8'hA3, 10'd512);
        check("full_ready", 32'(buf_in_ready), 32'd0);
        check("full_fill", 32'(fill_count), 32'd4);
        check("full_hasdata", 32'(buf_out_hasdata), 32'd1);
        write_byte(9'd0, 8'h5A);
        do_commit(10'd7, 1'b0);
        check("drop_fill", 32'(fill_count), 32'd4);
        repeat (4) consume();
        check("empty_hasdata", 32'(buf_out_hasdata), 32'd0);
        check("empty_len", 32'(buf_out_len), 32'd0);
        check("empty_ready", 32'(buf_in_ready), 32'd1);
        check("empty_fill", 32'(fill_count), 32'd0);

        // Pointer wrap over ten passes
        for (int i = 0; i < 10; i++) begin
            push_pkt(9'(i * 37 + 1), 8'(8'h10 + i), 10'(i * 7 + 1));
            consume();
        end

        // Commit and arm together at count=2
        push_pkt(9'd2, 8'hC0, 10'd20);
        push_pkt(9'd3, 8'hC1, 10'd21);
        write_byte(9'd4, 8'hC2);
        read_head();
        buf_in_commit = 1'b1; buf_in_commit_len = 10'd22; buf_out_arm = 1'b1;
        tick();
        buf_in_commit = 1'b0; buf_out_arm = 1'b0;
        check("both_cack", 32'(buf_in_commit_ack), 32'd1);
        check("both_aack", 32'(buf_out_arm_ack), 32'd1);
        check("both_fill", 32'(fill_count), 32'd2);
        begin
            pkt_t p;
            p.addr = 9'd4; p.b = 8'hC2; p.len = 10'd22;
            sb.push_back(p);
        end
        consume();
        consume();

        // Length clamp
        push_pkt(9'h1FF, 8'h77, 10'd600);
        consume();

        // Isoch toggle sequences
        mode = 2'd1; mult = 2'd3;
        tog_step(1'b1, 1'b0, 1'b0, 2'd2);
        tog_step(1'b0, 1'b0, 1'b1, 2'd1);
        tog_step(1'b0, 1'b0, 1'b1, 2'd0);
        tog_step(1'b0, 1'b0, 1'b1, 2'd0);
        mult = 2'd2;
        tog_step(1'b1, 1'b0, 1'b1, 2'd1);
        mult = 2'd0;
        tog_step(1'b1, 1'b0, 1'b0, 2'd0);

        // Bulk toggle sequence
        mode = 2'd2;
        tog_step(1'b0, 1'b1, 1'b0, 2'd0);
        tog_step(1'b0, 1'b0, 1'b1, 2'd1);
        tog_step(1'b0, 1'b0, 1'b1, 2'd0);
        tog_step(1'b0, 1'b0, 1'b1, 2'd1);
        tog_step(1'b0, 1'b1, 1'b1, 2'd0);

        // Full: simultaneous arm frees a slot but the commit is dropped
        push_pkt(9'd8, 8'hD0, 10'd30);
        push_pkt(9'd8, 8'hD1, 10'd31);
        push_pkt(9'd8, 8'hD2, 10'd32);
        push_pkt(9'd8, 8'hD3, 10'd33);
        read_head();
        buf_in_commit = 1'b1; buf_in_commit_len = 10'd40; buf_out_arm = 1'b1;
        tick();
        buf_in_commit = 1'b0; buf_out_arm = 1'b0;
        check("fullboth_cack", 32'(buf_in_commit_ack), 32'd0);
        check("fullboth_aack", 32'(buf_out_arm_ack), 32'd1);
        check("fullboth_fill", 32'(fill_count), 32'd3);
        check("fullboth_ready", 32'(buf_in_ready), 32'd1);

        // Async reset at count=3 with a non-zero toggle
        mode = 2'd1; mult = 2'd3;
        tog_step(1'b1, 1'b0, 1'b0, 2'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_fill", 32'(fill_count), 32'd0);
        check("arst_hasdata", 32'(buf_out_hasdata), 32'd0);
        check("arst_toggle", 32'(data_toggle), 32'd0);
        check("arst_ready", 32'(buf_in_ready), 32'd1);
        check("arst_len", 32'(buf_out_len), 32'd0);
        sb.delete();
        tick();
        reset_n = 1'b1;
        mode = 2'd2;
        tick();

        // Recovery after reset
        push_pkt(9'd9, 8'hE5, 10'd5);
        consume();

`ifdef USB2_EP_HALT_EN
        // Halt blocks the consumer; clear restores it and forces DATA0
        tog_step(1'b0, 1'b0, 1'b1, 2'd1);
        push_pkt(9'd10, 8'hF0, 10'd11);
        halt_set = 1'b1;
        tick();
        halt_set = 1'b0;
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_hasdata", 32'(buf_out_hasdata), 32'd0);
        do_arm(1'b0);
        check("halt_fill", 32'(fill_count), 32'd1);
        halt_clr = 1'b1;
        tick();
        halt_clr = 1'b0;
        check("unhalt_flag", 32'(halted), 32'd0);
        check("unhalt_hasdata", 32'(buf_out_hasdata), 32'd1);
        check("unhalt_toggle", 32'(data_toggle), 32'd0);
        consume();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
